plugboard_ctrl: RTL and testbench

Configuration controller and substitution engine for the Enigma plugboard stage. It captures up to MAX_PAIRS letter pairs from one-hot keyboard strobes in configuration mode and rejects illegal entries. In run mode it applies the committed pairs to each one-hot letter travelling between the keyboard and the rotor/reflector stack; the same block also serves the return path toward the display.

---
 rtl/plugboard_ctrl.sv | 154 +++++++++++++++
 tb/tb_plugboard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plugboard_ctrl.sv
// Enigma plugboard: captures swap pairs in configuration mode and substitutes one-hot letters.
// Optional PLUG_UNDO_EN adds an undo strobe that pops the pending letter or the newest pair.
module plugboard_ctrl #(
  parameter int unsigned MAX_PAIRS = 10,
  parameter int unsigned LETTERS   = 26
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               cfg_mode,
  input  logic               key_valid,
  input  logic [LETTERS-1:0] key_in,
  input  logic               clear,
`ifdef PLUG_UNDO_EN
  input  logic               undo,
`endif
  input  logic               in_valid,
  input  logic [LETTERS-1:0] in,
  output logic               out_valid,
  output logic [LETTERS-1:0] out,
  output logic [3:0]         pair_count,
  output logic               pending,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, WAIT_SECOND} state_t;

  state_t             state_q, state_d;
  logic [LETTERS-1:0] slot_a [MAX_PAIRS];
  logic [LETTERS-1:0] slot_b [MAX_PAIRS];
  logic [LETTERS-1:0] used;
  logic [LETTERS-1:0] first_reg;
  logic [LETTERS-1:0] sub_out;
  logic [LETTERS-1:0] last_mask;
  logic               undo_req;
  logic               commit, drop_last, latch_first, reject;
  logic               key_onehot, full;

  function automatic logic is_onehot(input logic [LETTERS-1:0] v);
    return (v != '0) && ((v & (v - LETTERS'(1))) == '0);
  endfunction

`ifdef PLUG_UNDO_EN
  assign undo_req = undo;
`else
  assign undo_req = 1'b0;
`endif

  assign key_onehot = is_onehot(key_in);
  assign full       = (pair_count == 4'(MAX_PAIRS));
  assign pending    = (state_q == WAIT_SECOND);

  // clear and cfg_mode=0 override everything; an undo that has nothing to remove lets the key through
  always_comb begin
    state_d     = state_q;
    commit      = 1'b0;
    drop_last   = 1'b0;
    latch_first = 1'b0;
    reject      = 1'b0;
    if (clear) begin
      state_d = cfg_mode ? WAIT_FIRST : IDLE;
    end else if (!cfg_mode) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_FIRST;
        WAIT_FIRST: begin
          if (undo_req && pair_count != 4'd0) begin
            drop_last = 1'b1;
          end else if (key_valid) begin
            if (key_onehot && (key_in & used) == '0 && !full) begin
              latch_first = 1'b1;
              state_d     = WAIT_SECOND;
            end else begin
              reject = 1'b1;
            end
          end
        end
        WAIT_SECOND: begin
          if (undo_req) begin
            state_d = WAIT_FIRST;
          end else if (key_valid) begin
            if (key_onehot && key_in != first_reg && (key_in & used) == '0) begin
              commit  = 1'b1;
              state_d = WAIT_FIRST;
            end else begin
              reject = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sub_out   = in;
    last_mask = '0;
    for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
      if (4'(i) < pair_count) begin
        if (in == slot_a[i])      sub_out = slot_b[i];
        else if (in == slot_b[i]) sub_out = slot_a[i];
      end
      if (4'(i) == pair_count - 4'd1) last_mask = slot_a[i] | slot_b[i];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      used       <= '0;
      first_reg  <= '0;
      pair_count <= 4'd0;
      err        <= 1'b0;
      out        <= '0;
      out_valid  <= 1'b0;
      for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
        slot_a[i] <= '0;
        slot_b[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      err       <= reject;
      out_valid <= in_valid;
      if (in_valid) out <= sub_out;

      if (clear) begin
        pair_count <= 4'd0;
        used       <= '0;
        first_reg  <= '0;
      end else if (commit) begin
        for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
          if (4'(i) == pair_count) begin
            slot_a[i] <= first_reg;
            slot_b[i] <= key_in;
          end
        end
        pair_count <= pair_count + 4'd1;
        used       <= used | first_reg | key_in;
      end else if (drop_last) begin
        for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
          if (4'(i) == pair_count - 4'd1) begin
            slot_a[i] <= '0;
            slot_b[i] <= '0;
          end
        end
        pair_count <= pair_count - 4'd1;
        used       <= used & ~last_mask;
      end else if (latch_first) begin
        first_reg <= key_in;
      end
    end
  end

endmodule

// File: tb/tb_plugboard_ctrl.sv
// Directed self-checking bench for plugboard_ctrl; define PLUG_UNDO_EN to exercise undo.
module tb_plugboard_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_mode = 1'b0;
  logic        key_valid = 1'b0;
  logic [25:0] key_in = '0;
  logic        clear = 1'b0;
  logic        undo = 1'b0;
  logic        in_valid = 1'b0;
  logic [25:0] in = '0;
  logic        out_valid;
  logic [25:0] out;
  logic [3:0]  pair_count;
  logic        pending;
  logic        err;

  int checks = 0;
  int failures = 0;

  plugboard_ctrl #(.MAX_PAIRS(10), .LETTERS(26)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .cfg_mode  (cfg_mode),
    .key_valid (key_valid),
    .key_in    (key_in),
    .clear     (clear),
`ifdef PLUG_UNDO_EN
    .undo      (undo),
`endif
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out),
    .pair_count(pair_count),
    .pending   (pending),
    .err       (err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [25:0] L(input int n);
    return 26'(1) << n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic [25:0] k);
    @(negedge CLOCK_50);
    key_valid = 1'b1;
    key_in    = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic sub(input string tag, input logic [25:0] x, input logic [25:0] exp);
    @(negedge CLOCK_50);
    in_valid = 1'b1;
    in       = x;
    tick();
    in_valid = 1'b0;
    check({tag, "_out"}, 32'(out), 32'(exp));
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    // reset values
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_cnt", 32'(pair_count), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;

    // pass-through with no pairs, then out holds
    sub("pass_a", L(0), L(0));
    check("pass_cnt", 32'(pair_count), 32'd0);
    tick();
    check("idle_vld", 32'(out_valid), 32'd0);
    check("hold_out", 32'(out), 32'(L(0)));

    // ignored key in IDLE
    press(L(0));
    check("idle_key_err", 32'(err), 32'd0);
    check("idle_key_pend", 32'(pending), 32'd0);

    // enter config, pair A-C
    @(negedge CLOCK_50);
    cfg_mode = 1'b1;
    tick();
    press(L(0));
    check("a_pend", 32'(pending), 32'd1);
    check("a_err", 32'(err), 32'd0);
    press(L(2));
    check("ac_cnt", 32'(pair_count), 32'd1);
    check("ac_pend", 32'(pending), 32'd0);
    sub("sub_c", L(2), L(0));
    sub("sub_a", L(0), L(2));
    sub("sub_b", L(1), L(1));

    // rejections, back-to-back err
    press(L(2));
    check("used_err", 32'(err), 32'd1);
    check("used_cnt", 32'(pair_count), 32'd1);
    press(L(1));
    check("b_err", 32'(err), 32'd0);
    check("b_pend", 32'(pending), 32'd1);
    press(L(1));
    check("bb_err", 32'(err), 32'd1);
    check("bb_pend", 32'(pending), 32'd1);
    press(L(1));
    check("bb2_err", 32'(err), 32'd1);
    press(L(3));
    check("bd_cnt", 32'(pair_count), 32'd2);
    check("bd_pend", 32'(pending), 32'd0);
    check("bd_err", 32'(err), 32'd0);
    sub("sub_d", L(3), L(1));

    // fill to 10 pairs: E-F .. S-T
    for (int p = 0; p < 8; p++) begin
      press(L(4 + 2 * p));
      press(L(5 + 2 * p));
    end
    check("full_cnt", 32'(pair_count), 32'd10);
    press(L(25));
    check("full_err", 32'(err), 32'd1);
    check("full_cnt2", 32'(pair_count), 32'd10);
    check("full_pend", 32'(pending), 32'd0);
    press(26'h3);
    check("twohot_full_err", 32'(err), 32'd1);
    sub("sub_t", L(19), L(18));
    sub("sub_z", L(25), L(25));

    // clear with in_valid on the same edge uses pre-clear pairs
    @(negedge CLOCK_50);
    clear    = 1'b1;
    in_valid = 1'b1;
    in       = L(0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_sub_out", 32'(out), 32'(L(2)));
    check("clr_cnt", 32'(pair_count), 32'd0);
    sub("post_clr_a", L(0), L(0));
    press(26'h3);
    check("twohot_err", 32'(err), 32'd1);
    check("twohot_cnt", 32'(pair_count), 32'd0);
    press(26'h0);
    check("zero_err", 32'(err), 32'd1);

    // dropping cfg_mode discards pending letter silently
    press(L(0));
    check("drop_pend1", 32'(pending), 32'd1);
    @(negedge CLOCK_50);
    cfg_mode = 1'b0;
    tick();
    check("drop_pend0", 32'(pending), 32'd0);
    check("drop_err", 32'(err), 32'd0);
    @(negedge CLOCK_50);
    cfg_mode = 1'b1;
    tick();

    // clear beats key_valid in the same cycle
    press(L(0));
    press(L(2));
    check("ac2_cnt", 32'(pair_count), 32'd1);
    @(negedge CLOCK_50);
    clear     = 1'b1;
    key_valid = 1'b1;
    key_in    = L(4);
    tick();
    clear     = 1'b0;
    key_valid = 1'b0;
    check("clrkey_cnt", 32'(pair_count), 32'd0);
    check("clrkey_pend", 32'(pending), 32'd0);
    check("clrkey_err", 32'(err), 32'd0);
    press(L(4));
    check("e_pend", 32'(pending), 32'd1);
    press(L(2));
    check("ec_cnt", 32'(pair_count), 32'd1);
    sub("sub_ec", L(2), L(4));

    // asynchronous reset mid-entry
    press(L(5));
    check("mid_pend", 32'(pending), 32'd1);
    @(negedge CLOCK_50);
    #1 reset = 1'b0;
    #1;
    check("arst_pend", 32'(pending), 32'd0);
    check("arst_cnt", 32'(pair_count), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;

    // asynchronous reset mid-substitution
    @(negedge CLOCK_50);
    in_valid = 1'b1;
    in       = L(2);
    #2 reset = 1'b0;
    tick();
    in_valid = 1'b0;
    check("arst_vld", 32'(out_valid), 32'd0);
    check("arst_out", 32'(out), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    tick();

`ifdef PLUG_UNDO_EN
    press(L(0));
    press(L(2));
    press(L(1));
    press(L(3));
    check("undo_pre_cnt", 32'(pair_count), 32'd2);
    @(negedge CLOCK_50);
    undo = 1'b1;
    tick();
    undo = 1'b0;
    check("undo_cnt", 32'(pair_count), 32'd1);
    sub("undo_sub_d", L(3), L(3));
    sub("undo_sub_a", L(0), L(2));
    press(L(3));
    check("undo_d_pend", 32'(pending), 32'd1);
    check("undo_d_err", 32'(err), 32'd0);
    @(negedge CLOCK_50);
    undo = 1'b1;
    tick();
    undo = 1'b0;
    check("undo2_pend", 32'(pending), 32'd0);
    check("undo2_cnt", 32'(pair_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
